// File: rtl/etherparse_axis_pkg.sv
// Shared types for the AXI-stream ingress buffer: FSM states, default widths and beat payload.
package etherparse_axis_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned USER_W = 1;
   localparam int unsigned KEEP_W = DATA_W / 8;

   typedef enum logic {
      PASS = 1'b0,
      DROP = 1'b1
   } ingress_state_e;

   // Beat payload at the default widths; the top re-declares it with its own parameters.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic              last;
      logic [USER_W-1:0] user;
      logic              err;
   } beat_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Generic synchronous FIFO of DEPTH x WIDTH; occupancy counter drives full/empty.
module axis_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign do_wr   = wr & ~full;
   assign do_rd   = rd & ~empty;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Storage array; no reset needed, validity is tracked by count.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally at DEPTH; count tracks occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axis_ingress_buf.sv
// Buffered AXI-stream ingress: FIFO decoupling plus max-frame-length truncation.
// Optional statistics counters enabled by defining AXIS_INGRESS_STATS_EN.
module axis_ingress_buf
   import etherparse_axis_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned USER_WIDTH = 1,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned MAX_BEATS  = 190
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     s_tdata,
   input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
   input  logic                      s_tvalid,
   output logic                      s_tready,
   input  logic                      s_tlast,
   input  logic [USER_WIDTH-1:0]     s_tuser,
   output logic [DATA_WIDTH-1:0]     m_tdata,
   output logic [DATA_WIDTH/8-1:0]   m_tkeep,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic                      m_tlast,
   output logic [USER_WIDTH-1:0]     m_tuser,
   output logic                      m_terr,
   output logic [$clog2(DEPTH):0]    fill_level
`ifdef AXIS_INGRESS_STATS_EN
   ,
   output logic [31:0]               stat_frames,
   output logic [31:0]               stat_trunc
`endif
);

   localparam int unsigned KW     = DATA_WIDTH / 8;
   localparam int unsigned BCNT_W = $clog2(MAX_BEATS + 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [KW-1:0]         keep;
      logic                  last;
      logic [USER_WIDTH-1:0] user;
      logic                  err;
   } ing_beat_t;

   localparam int unsigned BEAT_W = $bits(ing_beat_t);

   ingress_state_e    state;
   ingress_state_e    state_nxt;
   logic [BCNT_W-1:0] beat_cnt;
   logic [BCNT_W-1:0] beat_cnt_nxt;
   ing_beat_t         wr_beat;
   ing_beat_t         rd_beat;
   logic              accept;
   logic              wr_en;
   logic              truncate;
   logic              full;
   logic              empty;
   logic              rd_en;

   // DROP sinks beats regardless of FIFO space; PASS only takes beats it can store.
   assign s_tready = ~rst & ((state == DROP) | ~full);
   assign accept   = s_tvalid & s_tready;
   assign m_tvalid = ~empty;
   assign rd_en    = m_tvalid & m_tready;

   axis_sync_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr_en),
      .wr_data (wr_beat),
      .rd      (rd_en),
      .rd_data (rd_beat),
      .full    (full),
      .empty   (empty),
      .count   (fill_level)
   );

   // Egress payload held at zero whenever no beat is offered.
   assign m_tdata = m_tvalid ? rd_beat.data : '0;
   assign m_tkeep = m_tvalid ? rd_beat.keep : '0;
   assign m_tlast = m_tvalid ? rd_beat.last : 1'b0;
   assign m_tuser = m_tvalid ? rd_beat.user : '0;
   assign m_terr  = m_tvalid ? rd_beat.err  : 1'b0;

   // State and beat counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= PASS;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   // Next state, beat counting and truncation of oversize frames.
   always_comb begin
      state_nxt    = state;
      beat_cnt_nxt = beat_cnt;
      wr_en        = 1'b0;
      truncate     = 1'b0;
      wr_beat      = '{data: s_tdata, keep: s_tkeep, last: s_tlast, user: s_tuser, err: 1'b0};
      case (state)
         PASS: begin
            if (accept) begin
               wr_en = 1'b1;
               if (s_tlast) begin
                  beat_cnt_nxt = '0;
               end else if (beat_cnt == BCNT_W'(MAX_BEATS - 1)) begin
                  truncate     = 1'b1;
                  wr_beat.last = 1'b1;
                  wr_beat.err  = 1'b1;
                  beat_cnt_nxt = '0;
                  state_nxt    = DROP;
               end else begin
                  beat_cnt_nxt = beat_cnt + BCNT_W'(1);
               end
            end
         end
         DROP: begin
            if (accept && s_tlast) state_nxt = PASS;
         end
      endcase
   end

`ifdef AXIS_INGRESS_STATS_EN
   // Frame and truncation counters; both wrap at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_frames <= '0;
         stat_trunc  <= '0;
      end else begin
         if (wr_en && wr_beat.last) stat_frames <= stat_frames + 32'd1;
         if (truncate)              stat_trunc  <= stat_trunc + 32'd1;
      end
   end
`endif

endmodule
